// File: rtl/lsu_pkg.sv
// Shared constants for the load/store unit: datapath widths, RV32I load/store
// funct3 codes, FSM state encoding and the alignment check helper.
package lsu_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_ADDR_W = 5;

  // RV32I load funct3 codes
  localparam logic [2:0] Funct3Lb  = 3'd0;
  localparam logic [2:0] Funct3Lh  = 3'd1;
  localparam logic [2:0] Funct3Lw  = 3'd2;
  localparam logic [2:0] Funct3Lbu = 3'd4;
  localparam logic [2:0] Funct3Lhu = 3'd5;

  // RV32I store funct3 codes
  localparam logic [2:0] Funct3Sb  = 3'd0;
  localparam logic [2:0] Funct3Sh  = 3'd1;
  localparam logic [2:0] Funct3Sw  = 3'd2;

  // FSM state encoding
  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StBusy = 1'b1;

  // funct3[1:0] encodes the access size for both loads and stores:
  // 01 = half (needs addr[0] clear), 10 = word (needs addr[1:0] clear).
  function automatic logic is_misaligned(logic [2:0] funct3, logic [1:0] offset);
    logic mis;
    mis = 1'b0;
    case (funct3[1:0])
      2'b01:   mis = offset[0];
      2'b10:   mis = (offset != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Data-memory bus between the lsu (master) and memory (slave).
//   mem_req   : request, held high until mem_ack
//   mem_we    : 1 = write
//   mem_addr  : word-aligned address
//   mem_wdata : lane-positioned store data
//   mem_wstrb : byte enables
//   mem_ack   : memory completes the access this cycle
//   mem_rdata : read word, valid with mem_ack
interface lsu_if;
  import lsu_pkg::*;

  logic            mem_req;
  logic            mem_we;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic [3:0]      mem_wstrb;
  logic            mem_ack;
  logic [XLEN-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output mem_ack, mem_rdata
  );

endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic for byte/half/word accesses.
//   st_funct3, st_offset, st_data : store funct3, addr[1:0], rs2 value
//   st_wdata, st_wstrb            : lane-replicated store data and byte enables
//   ld_funct3, ld_offset, ld_rdata: load funct3, addr[1:0], raw memory word
//   ld_data                       : extracted and sign/zero-extended load value
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]      st_funct3,
  input  logic [1:0]      st_offset,
  input  logic [XLEN-1:0] st_data,
  output logic [XLEN-1:0] st_wdata,
  output logic [3:0]      st_wstrb,
  input  logic [2:0]      ld_funct3,
  input  logic [1:0]      ld_offset,
  input  logic [XLEN-1:0] ld_rdata,
  output logic [XLEN-1:0] ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    st_wdata = st_data;
    st_wstrb = 4'b0000;
    case (st_funct3)
      Funct3Sb: begin
        st_wdata = {4{st_data[7:0]}};
        st_wstrb = 4'b0001 << st_offset;
      end
      Funct3Sh: begin
        st_wdata = {2{st_data[15:0]}};
        st_wstrb = st_offset[1] ? 4'b1100 : 4'b0011;
      end
      Funct3Sw: begin
        st_wdata = st_data;
        st_wstrb = 4'b1111;
      end
      default: begin
        st_wdata = st_data;
        st_wstrb = 4'b0000;
      end
    endcase
  end

  always_comb begin
    ld_byte = ld_rdata[{ld_offset, 3'b000} +: 8];
    ld_half = ld_offset[1] ? ld_rdata[31:16] : ld_rdata[15:0];
    case (ld_funct3)
      Funct3Lb:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      Funct3Lh:  ld_data = {{16{ld_half[15]}}, ld_half};
      Funct3Lbu: ld_data = {24'd0, ld_byte};
      Funct3Lhu: ld_data = {16'd0, ld_half};
      default:   ld_data = ld_rdata;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit downstream of EX. Retires non-memory results in one cycle,
// performs byte/half/word memory accesses over a req/ack bus and stalls EX via
// in_ready while an access is outstanding. Flags misaligned/illegal accesses
// and accesses that see no ack within ACK_TIMEOUT cycles.
//   clk, rst        : clock, asynchronous active-high reset
//   in_*            : EX stage handshake and instruction fields
//   mem             : data-memory bus (master side)
//   wb_*, lsu_err   : registered writeback pulse and error flag
module lsu
  import lsu_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_load,
  input  logic                  in_store,
  input  logic [2:0]            in_funct3,
  input  logic [XLEN-1:0]       in_addr,
  input  logic [XLEN-1:0]       in_wdata,
  input  logic [XLEN-1:0]       in_result,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic                  in_rd_we,
  lsu_if.master                 mem,
  output logic                  wb_valid,
  output logic                  wb_we,
  output logic [REG_ADDR_W-1:0] wb_rd,
  output logic [XLEN-1:0]       wb_data,
  output logic                  lsu_err
);

  localparam int unsigned CntW = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(ACK_TIMEOUT - 1);

  logic [0:0]            state_q;
  logic [CntW-1:0]       cnt_q;
  logic                  req_q, we_q;
  logic [XLEN-1:0]       addr_q, wdata_q;
  logic [3:0]            wstrb_q;
  logic                  is_load_q, rd_we_q;
  logic [REG_ADDR_W-1:0] rd_q;
  logic [2:0]            funct3_q;
  logic [1:0]            offset_q;

  logic                  accept, is_mem, illegal, misaligned;
  logic [XLEN-1:0]       st_wdata, ld_data;
  logic [3:0]            st_wstrb;

  assign in_ready   = !rst && (state_q == StIdle);
  assign accept     = in_valid && in_ready;
  assign is_mem     = in_load || in_store;
  assign misaligned = is_misaligned(in_funct3, in_addr[1:0]);

  always_comb begin
    illegal = 1'b0;
    if (in_load && in_store) begin
      illegal = 1'b1;
    end else if (in_load) begin
      illegal = !(in_funct3 inside {Funct3Lb, Funct3Lh, Funct3Lw, Funct3Lbu, Funct3Lhu});
    end else if (in_store) begin
      illegal = !(in_funct3 inside {Funct3Sb, Funct3Sh, Funct3Sw});
    end
  end

  lsu_align u_align (
    .st_funct3 (in_funct3),
    .st_offset (in_addr[1:0]),
    .st_data   (in_wdata),
    .st_wdata  (st_wdata),
    .st_wstrb  (st_wstrb),
    .ld_funct3 (funct3_q),
    .ld_offset (offset_q),
    .ld_rdata  (mem.mem_rdata),
    .ld_data   (ld_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= 4'b0000;
      is_load_q <= 1'b0;
      rd_we_q   <= 1'b0;
      rd_q      <= '0;
      funct3_q  <= 3'd0;
      offset_q  <= 2'b00;
      wb_valid  <= 1'b0;
      wb_we     <= 1'b0;
      wb_rd     <= '0;
      wb_data   <= '0;
      lsu_err   <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      lsu_err  <= 1'b0;
      case (state_q)
        StIdle: begin
          if (accept) begin
            if (!is_mem) begin
              wb_valid <= 1'b1;
              wb_we    <= in_rd_we;
              wb_rd    <= in_rd;
              wb_data  <= in_result;
            end else if (illegal || misaligned) begin
              wb_valid <= 1'b1;
              wb_we    <= 1'b0;
              wb_rd    <= in_rd;
              wb_data  <= '0;
              lsu_err  <= 1'b1;
            end else begin
              state_q   <= StBusy;
              cnt_q     <= '0;
              req_q     <= 1'b1;
              we_q      <= in_store;
              addr_q    <= {in_addr[XLEN-1:2], 2'b00};
              wdata_q   <= in_store ? st_wdata : '0;
              wstrb_q   <= in_store ? st_wstrb : 4'b0000;
              is_load_q <= in_load;
              rd_we_q   <= in_rd_we;
              rd_q      <= in_rd;
              funct3_q  <= in_funct3;
              offset_q  <= in_addr[1:0];
            end
          end
        end
        StBusy: begin
          if (mem.mem_ack) begin
            state_q  <= StIdle;
            req_q    <= 1'b0;
            wb_valid <= 1'b1;
            wb_we    <= is_load_q && rd_we_q;
            wb_rd    <= rd_q;
            wb_data  <= is_load_q ? ld_data : '0;
          end else if (cnt_q == CntLast) begin
            // No ack within the budget: abort and report.
            state_q  <= StIdle;
            req_q    <= 1'b0;
            wb_valid <= 1'b1;
            wb_we    <= 1'b0;
            wb_rd    <= rd_q;
            wb_data  <= '0;
            lsu_err  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign mem.mem_req   = req_q;
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;
  assign mem.mem_wstrb = wstrb_q;

endmodule

// File: tb/tb_lsu.sv
module tb_lsu;
  import lsu_pkg::*;

  logic                  clk, rst;
  logic                  in_valid, in_ready, in_load, in_store;
  logic [2:0]            in_funct3;
  logic [XLEN-1:0]       in_addr, in_wdata, in_result;
  logic [REG_ADDR_W-1:0] in_rd;
  logic                  in_rd_we;
  logic                  wb_valid, wb_we, lsu_err;
  logic [REG_ADDR_W-1:0] wb_rd;
  logic [XLEN-1:0]       wb_data;

  lsu_if mem_bus ();

  lsu #(.ACK_TIMEOUT(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_load   (in_load),
    .in_store  (in_store),
    .in_funct3 (in_funct3),
    .in_addr   (in_addr),
    .in_wdata  (in_wdata),
    .in_result (in_result),
    .in_rd     (in_rd),
    .in_rd_we  (in_rd_we),
    .mem       (mem_bus),
    .wb_valid  (wb_valid),
    .wb_we     (wb_we),
    .wb_rd     (wb_rd),
    .wb_data   (wb_data),
    .lsu_err   (lsu_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic        err;
    logic        chk_data;
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic we, input logic err, input logic chk_data,
                      input logic [4:0] rd, input logic [31:0] data);
    exp_t e;
    e.we = we; e.err = err; e.chk_data = chk_data; e.rd = rd; e.data = data;
    sb.push_back(e);
  endtask

  // Scoreboard: every writeback pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && wb_valid) begin
      n_vec++;
      assert (sb.size() != 0) else begin
        n_err++;
        $error("FAIL unexpected_wb observed=wb_valid expected=none rd=%0d", wb_rd);
      end
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("wb_we", 32'(wb_we), 32'(e.we));
        chk("lsu_err", 32'(lsu_err), 32'(e.err));
        if (e.chk_data) begin
          chk("wb_rd", 32'(wb_rd), 32'(e.rd));
          chk("wb_data", wb_data, e.data);
        end
      end
    end
  end

  // Present one instruction for exactly one accepting edge; returns 1 after it.
  task automatic drive(input logic ld, input logic st, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] result, input logic [4:0] rd, input logic rd_we);
    chk("in_ready_idle", 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_load = ld; in_store = st; in_funct3 = f3;
    in_addr = addr; in_wdata = wdata; in_result = result; in_rd = rd; in_rd_we = rd_we;
    @(posedge clk); #1;
    in_valid = 1'b0; in_load = 1'b0; in_store = 1'b0;
  endtask

  // Wait n BUSY cycles without ack, then ack with rdata.
  task automatic ack_after(input int n, input logic [31:0] rdata);
    for (int i = 0; i < n; i++) begin
      chk("busy_in_ready", 32'(in_ready), 32'd0);
      chk("busy_req", 32'(mem_bus.mem_req), 32'd1);
      @(posedge clk); #1;
    end
    chk("ack_req", 32'(mem_bus.mem_req), 32'd1);
    mem_bus.mem_rdata = rdata;
    mem_bus.mem_ack   = 1'b1;
    @(posedge clk); #1;
    mem_bus.mem_ack = 1'b0;
    chk("post_ack_req", 32'(mem_bus.mem_req), 32'd0);
    chk("post_ack_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int req_cnt;
    rst = 1'b1; in_valid = 1'b0; in_load = 1'b0; in_store = 1'b0; in_funct3 = 3'd0;
    in_addr = '0; in_wdata = '0; in_result = '0; in_rd = '0; in_rd_we = 1'b0;
    mem_bus.mem_ack = 1'b0; mem_bus.mem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_req", 32'(mem_bus.mem_req), 32'd0);
    chk("rst_we", 32'(mem_bus.mem_we), 32'd0);
    chk("rst_wstrb", 32'(mem_bus.mem_wstrb), 32'd0);
    chk("rst_addr", mem_bus.mem_addr, 32'd0);
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_err", 32'(lsu_err), 32'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Non-memory, back to back
    push(1'b1, 1'b0, 1'b1, 5'd5, 32'h0000_0055);
    drive(1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 32'h0000_0055, 5'd5, 1'b1);
    chk("nonmem_req", 32'(mem_bus.mem_req), 32'd0);
    push(1'b0, 1'b0, 1'b1, 5'd6, 32'hDEAD_BEEF);
    drive(1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 32'hDEAD_BEEF, 5'd6, 1'b0);
    chk("nonmem2_req", 32'(mem_bus.mem_req), 32'd0);

    // SB 0x1003
    push(1'b0, 1'b0, 1'b0, 5'd7, 32'h0);
    drive(1'b0, 1'b1, Funct3Sb, 32'h0000_1003, 32'h0000_00AB, 32'h0, 5'd7, 1'b1);
    chk("sb_we", 32'(mem_bus.mem_we), 32'd1);
    chk("sb_addr", mem_bus.mem_addr, 32'h0000_1000);
    chk("sb_wstrb", 32'(mem_bus.mem_wstrb), 32'b1000);
    chk("sb_wdata", mem_bus.mem_wdata, 32'hABAB_ABAB);
    ack_after(2, 32'h0);

    // SH 0x1002, SW 0x1004
    push(1'b0, 1'b0, 1'b0, 5'd7, 32'h0);
    drive(1'b0, 1'b1, Funct3Sh, 32'h0000_1002, 32'h0000_BEEF, 32'h0, 5'd7, 1'b1);
    chk("sh_wstrb", 32'(mem_bus.mem_wstrb), 32'b1100);
    chk("sh_wdata", mem_bus.mem_wdata, 32'hBEEF_BEEF);
    ack_after(0, 32'h0);
    push(1'b0, 1'b0, 1'b0, 5'd7, 32'h0);
    drive(1'b0, 1'b1, Funct3Sw, 32'h0000_1004, 32'h1234_5678, 32'h0, 5'd7, 1'b1);
    chk("sw_wstrb", 32'(mem_bus.mem_wstrb), 32'b1111);
    chk("sw_wdata", mem_bus.mem_wdata, 32'h1234_5678);
    chk("sw_addr", mem_bus.mem_addr, 32'h0000_1004);
    ack_after(1, 32'h0);

    // Loads, ack in first BUSY cycle
    push(1'b1, 1'b0, 1'b1, 5'd8, 32'hFFFF_FF80);
    drive(1'b1, 1'b0, Funct3Lb, 32'h0000_2001, 32'h0, 32'h0, 5'd8, 1'b1);
    chk("lb_we", 32'(mem_bus.mem_we), 32'd0);
    chk("lb_wstrb", 32'(mem_bus.mem_wstrb), 32'd0);
    chk("lb_addr", mem_bus.mem_addr, 32'h0000_2000);
    ack_after(0, 32'h1234_80FF);
    push(1'b1, 1'b0, 1'b1, 5'd9, 32'h0000_0080);
    drive(1'b1, 1'b0, Funct3Lbu, 32'h0000_2001, 32'h0, 32'h0, 5'd9, 1'b1);
    ack_after(0, 32'h1234_80FF);
    push(1'b1, 1'b0, 1'b1, 5'd10, 32'h0000_1234);
    drive(1'b1, 1'b0, Funct3Lhu, 32'h0000_2002, 32'h0, 32'h0, 5'd10, 1'b1);
    ack_after(0, 32'h1234_80FF);
    push(1'b1, 1'b0, 1'b1, 5'd11, 32'hFFFF_80FF);
    drive(1'b1, 1'b0, Funct3Lh, 32'h0000_2000, 32'h0, 32'h0, 5'd11, 1'b1);
    ack_after(1, 32'h1234_80FF);
    push(1'b1, 1'b0, 1'b1, 5'd12, 32'hCAFE_F00D);
    drive(1'b1, 1'b0, Funct3Lw, 32'h0000_3000, 32'h0, 32'h0, 5'd12, 1'b1);
    ack_after(0, 32'hCAFE_F00D);
    // Load with rd_we = 0 must not write
    push(1'b0, 1'b0, 1'b0, 5'd13, 32'h0);
    drive(1'b1, 1'b0, Funct3Lw, 32'h0000_3000, 32'h0, 32'h0, 5'd13, 1'b0);
    ack_after(0, 32'h1111_2222);

    // Errors: misaligned LW, funct3=3 load, load+store, misaligned SH
    push(1'b0, 1'b1, 1'b0, 5'd1, 32'h0);
    drive(1'b1, 1'b0, Funct3Lw, 32'h0000_3002, 32'h0, 32'h0, 5'd1, 1'b1);
    chk("mis_lw_req", 32'(mem_bus.mem_req), 32'd0);
    push(1'b0, 1'b1, 1'b0, 5'd1, 32'h0);
    drive(1'b1, 1'b0, 3'd3, 32'h0000_3000, 32'h0, 32'h0, 5'd1, 1'b1);
    chk("ill_f3_req", 32'(mem_bus.mem_req), 32'd0);
    push(1'b0, 1'b1, 1'b0, 5'd1, 32'h0);
    drive(1'b1, 1'b1, Funct3Lw, 32'h0000_3000, 32'h0, 32'h0, 5'd1, 1'b1);
    chk("ill_ldst_req", 32'(mem_bus.mem_req), 32'd0);
    push(1'b0, 1'b1, 1'b0, 5'd1, 32'h0);
    drive(1'b0, 1'b1, Funct3Sh, 32'h0000_1001, 32'h0, 32'h0, 5'd1, 1'b1);
    chk("mis_sh_req", 32'(mem_bus.mem_req), 32'd0);
    chk("err_ready", 32'(in_ready), 32'd1);

    // Timeout: never ack
    push(1'b0, 1'b1, 1'b0, 5'd2, 32'h0);
    drive(1'b1, 1'b0, Funct3Lw, 32'h0000_4000, 32'h0, 32'h0, 5'd2, 1'b1);
    req_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (!mem_bus.mem_req) break;
      req_cnt++;
      @(posedge clk); #1;
    end
    chk("timeout_req_cycles", 32'(req_cnt), 32'd16);
    chk("timeout_ready", 32'(in_ready), 32'd1);

    // Reset mid-BUSY; late ack must be ignored
    drive(1'b1, 1'b0, Funct3Lw, 32'h0000_5000, 32'h0, 32'h0, 5'd3, 1'b1);
    chk("pre_rst_req", 32'(mem_bus.mem_req), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_req", 32'(mem_bus.mem_req), 32'd0);
    chk("async_rst_ready", 32'(in_ready), 32'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    mem_bus.mem_ack = 1'b1;
    @(posedge clk); #1;
    mem_bus.mem_ack = 1'b0;
    chk("late_ack_req", 32'(mem_bus.mem_req), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("late_ack_ready", 32'(in_ready), 32'd1);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
